// File: rtl/chip8_pkg.sv
// Shared CHIP-8 core definitions: default memory address width and the
// FX33 store sequencer state encoding.
package chip8_pkg;

    localparam int DEF_ADDR_W = 12;

    typedef enum logic [2:0] {
        IDLE,
        WR0,
        WR1,
        WR2,
        DONE
    } bcd_st_t;

endpackage

// File: rtl/chip8_bcd_store_bcd.sv
// Combinational byte-to-BCD converter: 2-bit hundreds, 4-bit tens, 4-bit ones.
module bcd (
    input  logic [7:0] bin,
    output logic [1:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    logic [7:0] rem_h;
    logic [7:0] rem_t;

    // Compare-and-subtract; the remainder after hundreds is always below 100.
    always_comb begin
        hundreds = 2'd0;
        rem_h    = bin;
        if (bin >= 8'd200) begin
            hundreds = 2'd2;
            rem_h    = bin - 8'd200;
        end else if (bin >= 8'd100) begin
            hundreds = 2'd1;
            rem_h    = bin - 8'd100;
        end

        tens  = 4'd0;
        rem_t = rem_h;
        for (int t = 1; t < 10; t++) begin
            if (rem_h >= 8'(10 * t)) begin
                tens  = 4'(t);
                rem_t = rem_h - 8'(10 * t);
            end
        end

        ones = 4'(rem_t);
    end

endmodule

// File: rtl/chip8_bcd_store.sv
// FX33 sequencer: latches VX and I, then writes hundreds/tens/ones of VX to
// I, I+1, I+2 through a ready-qualified RAM write port.
//
//   state | meaning
//   IDLE  | waiting for start
//   WR0   | writing hundreds to I
//   WR1   | writing tens to I+1
//   WR2   | writing ones to I+2
//   DONE  | one-cycle completion; start accepted here too
module chip8_bcd_store
    import chip8_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        value,
    input  logic [ADDR_W-1:0] base,
    output logic              busy,
    output logic              done,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ready
);

    bcd_st_t           state_q, state_d;
    logic [7:0]        val_q, val_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic [1:0] dig_h;
    logic [3:0] dig_t;
    logic [3:0] dig_o;

    bcd u_bcd (
        .bin      (val_q),
        .hundreds (dig_h),
        .tens     (dig_t),
        .ones     (dig_o)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            val_q   <= 8'd0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    val_d   = value;
                    addr_d  = base;
                    state_d = WR0;
                end else begin
                    state_d = IDLE;
                end
            end
            WR0:     if (mem_ready) state_d = WR1;
            WR1:     if (mem_ready) state_d = WR2;
            WR2:     if (mem_ready) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode only registered state, so a stall holds them stable.
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 8'd0;
        case (state_q)
            WR0: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = {6'd0, dig_h};
            end
            WR1: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_q + ADDR_W'(1);
                mem_wdata = {4'd0, dig_t};
            end
            WR2: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_q + ADDR_W'(2);
                mem_wdata = {4'd0, dig_o};
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_chip8_bcd_store.sv
// Directed self-checking bench for the FX33 BCD store sequencer.
module tb_chip8_bcd_store;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  value;
    logic [11:0] base;
    logic        busy;
    logic        done;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ready;

    int checks;
    int errors;

    int          wr_cnt;
    logic [11:0] wr_addr_q[$];
    logic [7:0]  wr_data_q[$];

    chip8_bcd_store #(.ADDR_W(12)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .value     (value),
        .base      (base),
        .busy      (busy),
        .done      (done),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs only change 1 time unit after a rising edge, so what is seen
    // at the falling edge is what the arbiter sees at the next rising edge.
    always @(negedge clk) begin
        if (mem_we && mem_ready) begin
            wr_cnt++;
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({busy, done, mem_we} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: busy/done/we=%b expected 000", {busy, done, mem_we});
        end
        checks++;
        if (mem_addr !== 12'h000 || mem_wdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_bus: addr=%h data=%h expected 000/00", mem_addr, mem_wdata);
        end
        rst_n = 1'b1;
        tick();
    endtask

    // Runs one operation with ready held high; checks each write cycle and done.
    task automatic test_basic(input string name, input logic [7:0] v, input logic [11:0] b,
                              input logic [11:0] ea0, input logic [11:0] ea1, input logic [11:0] ea2,
                              input logic [7:0] ed0, input logic [7:0] ed1, input logic [7:0] ed2);
        logic [11:0] ea[3];
        logic [7:0]  ed[3];
        int          w0;
        ea = '{ea0, ea1, ea2};
        ed = '{ed0, ed1, ed2};
        w0 = wr_cnt;
        mem_ready = 1'b1;
        start = 1'b1;
        value = v;
        base  = b;
        tick();
        start = 1'b0;
        value = 8'hAA;
        base  = 12'h555;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (mem_we !== 1'b1 || busy !== 1'b1 || done !== 1'b0 ||
                mem_addr !== ea[k] || mem_wdata !== ed[k]) begin
                errors++;
                $display("FAIL %s_wr%0d: we=%b busy=%b done=%b addr=%h data=%h expected 1/1/0 %h %h",
                         name, k, mem_we, busy, done, mem_addr, mem_wdata, ea[k], ed[k]);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL %s_done: done=%b busy=%b we=%b expected 1/0/0", name, done, busy, mem_we);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || mem_we !== 1'b0 || wr_cnt - w0 != 3) begin
            errors++;
            $display("FAIL %s_idle: done=%b busy=%b we=%b writes=%0d expected 0/0/0 3",
                     name, done, busy, mem_we, wr_cnt - w0);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] ea[6];
        logic [7:0]  ed[6];
        int          w0;
        ea = '{12'h200, 12'h201, 12'h202, 12'h400, 12'h401, 12'h402};
        ed = '{8'd0, 8'd9, 8'd9, 8'd1, 8'd0, 8'd0};
        w0 = wr_cnt;
        mem_ready = 1'b1;
        start = 1'b1;
        value = 8'd99;
        base  = 12'h200;
        tick();
        value = 8'd100;
        base  = 12'h400;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== ea[k] || mem_wdata !== ed[k]) begin
                errors++;
                $display("FAIL b2b_first_wr%0d: we=%b addr=%h data=%h expected 1 %h %h",
                         k, mem_we, mem_addr, mem_wdata, ea[k], ed[k]);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done1: done=%b busy=%b expected 1/0", done, busy);
        end
        tick();
        start = 1'b0;
        for (int k = 3; k < 6; k++) begin
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== ea[k] || mem_wdata !== ed[k]) begin
                errors++;
                $display("FAIL b2b_second_wr%0d: we=%b addr=%h data=%h expected 1 %h %h",
                         k - 3, mem_we, mem_addr, mem_wdata, ea[k], ed[k]);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done2: done=%b expected 1", done);
        end
        tick();
        checks++;
        if (wr_cnt - w0 != 6) begin
            errors++;
            $display("FAIL b2b_count: writes=%0d expected 6", wr_cnt - w0);
        end
    endtask

    task automatic test_stall();
        int w0;
        int lat;
        w0 = wr_cnt;
        lat = 0;
        mem_ready = 1'b1;
        start = 1'b1;
        value = 8'd137;
        base  = 12'h300;
        tick();
        start = 1'b0;
        checks++;
        if (mem_addr !== 12'h300 || mem_wdata !== 8'd1) begin
            errors++;
            $display("FAIL stall_wr0: addr=%h data=%h expected 300 01", mem_addr, mem_wdata);
        end
        tick();
        lat++;
        mem_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (mem_we !== 1'b1 || busy !== 1'b1 || mem_addr !== 12'h301 || mem_wdata !== 8'd3) begin
                errors++;
                $display("FAIL stall_hold%0d: we=%b busy=%b addr=%h data=%h expected 1/1 301 03",
                         s, mem_we, busy, mem_addr, mem_wdata);
            end
            tick();
            lat++;
        end
        mem_ready = 1'b1;
        checks++;
        if (mem_addr !== 12'h301 || mem_wdata !== 8'd3) begin
            errors++;
            $display("FAIL stall_release: addr=%h data=%h expected 301 03", mem_addr, mem_wdata);
        end
        tick();
        lat++;
        checks++;
        if (mem_addr !== 12'h302 || mem_wdata !== 8'd7) begin
            errors++;
            $display("FAIL stall_wr2: addr=%h data=%h expected 302 07", mem_addr, mem_wdata);
        end
        tick();
        lat++;
        checks++;
        if (done !== 1'b1 || lat != 6) begin
            errors++;
            $display("FAIL stall_done: done=%b edges_after_accept=%0d expected 1 6", done, lat);
        end
        checks++;
        if (wr_cnt - w0 != 3 || wr_addr_q[w0+1] !== 12'h301 || wr_data_q[w0+1] !== 8'd3) begin
            errors++;
            $display("FAIL stall_writes: count=%0d expected 3 (no duplicates)", wr_cnt - w0);
        end
        tick();
    endtask

    task automatic test_ignore_start();
        logic [11:0] ea[3];
        logic [7:0]  ed[3];
        int          w0;
        ea = '{12'h100, 12'h101, 12'h102};
        ed = '{8'd2, 8'd0, 8'd0};
        w0 = wr_cnt;
        mem_ready = 1'b1;
        start = 1'b1;
        value = 8'd200;
        base  = 12'h100;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        value = 8'd42;
        base  = 12'h500;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL ign_done: done=%b expected 1", done);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL ign_idle: busy=%b done=%b we=%b expected 0/0/0", busy, done, mem_we);
        end
        tick();
        checks++;
        if (wr_cnt - w0 != 3 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ign_count: writes=%0d busy=%b expected 3 0", wr_cnt - w0, busy);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (wr_addr_q[w0+k] !== ea[k] || wr_data_q[w0+k] !== ed[k]) begin
                errors++;
                $display("FAIL ign_wr%0d: addr=%h data=%h expected %h %h",
                         k, wr_addr_q[w0+k], wr_data_q[w0+k], ea[k], ed[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int w0;
        w0 = wr_cnt;
        mem_ready = 1'b1;
        start = 1'b1;
        value = 8'd254;
        base  = 12'h300;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if (mem_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_ctrl: we=%b busy=%b done=%b expected 0/0/0", mem_we, busy, done);
        end
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (wr_cnt - w0 != 2 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_count: writes=%0d we=%b expected 2 0", wr_cnt - w0, mem_we);
        end
        test_basic("rstmid_after", 8'd5, 12'h010, 12'h010, 12'h011, 12'h012, 8'd0, 8'd0, 8'd5);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        wr_cnt    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        value     = 8'd0;
        base      = 12'h000;
        mem_ready = 1'b1;
        #1;
        test_reset();
        test_basic("basic254", 8'd254, 12'h300, 12'h300, 12'h301, 12'h302, 8'd2, 8'd5, 8'd4);
        test_basic("wrap", 8'd0, 12'hFFE, 12'hFFE, 12'hFFF, 12'h000, 8'd0, 8'd0, 8'd0);
        test_basic("v255", 8'd255, 12'h7FF, 12'h7FF, 12'h800, 12'h801, 8'd2, 8'd5, 8'd5);
        test_back_to_back();
        test_stall();
        test_ignore_start();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
